// File: rtl/video_pkg.sv
// Shared 640x480@60 raster timing constants used by the HDMI top level and the timing generator.
package video_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FRAME_W   = 8;
    localparam int unsigned MAX_TOTAL = 1024;

    // Bit order matches the sig_delay bus: {draw, vsync, hsync}
    typedef struct packed {
        logic draw;
        logic vsync;
        logic hsync;
    } sync_bits_t;

endpackage

// File: rtl/sig_delay.sv
// Enable-gated shift register; every stage clears asynchronously to RST_VAL.
module sig_delay #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled cycle; the last stage is the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, frame/line pulses and delay-aligned sync/draw strobes.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_draw_area,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned EXT_W    = COORD_W + 1;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [EXT_W-1:0]   HS_START = EXT_W'(H_ACTIVE + H_FP);
    localparam logic [EXT_W-1:0]   HS_END   = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EXT_W-1:0]   VS_START = EXT_W'(V_ACTIVE + V_FP);
    localparam logic [EXT_W-1:0]   VS_END   = EXT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [EXT_W-1:0]   H_ACT_E  = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0]   V_ACT_E  = EXT_W'(V_ACTIVE);

    localparam sync_bits_t SYNC_IDLE = '{draw: 1'b0, vsync: ~VS_POL, hsync: ~HS_POL};

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
        if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
            $error("video_timing_gen: PIPE_DLY must be 1..4");
        end
    endgenerate

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [EXT_W-1:0]   w_x_ext;
    logic [EXT_W-1:0]   w_y_ext;
    logic               w_line_start;
    sync_bits_t         w_raw;
    sync_bits_t         w_dly_out;

    // Raster counters: x wraps into y, y wraps into the frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= 10'd0;
            r_y         <= 10'd0;
            r_frame_cnt <= 8'd0;
        end else if (en) begin
            if (r_x == H_LAST) begin
                r_x <= 10'd0;
                if (r_y == V_LAST) begin
                    r_y         <= 10'd0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_y <= r_y + 10'd1;
                end
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Compare in 11 bits so a window ending exactly at 1024 still decodes.
    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};

    // Raw strobes, already at their output polarity so the delay line's last stage is the output register.
    always_comb begin
        w_raw       = SYNC_IDLE;
        w_raw.hsync = ((w_x_ext >= HS_START) && (w_x_ext < HS_END)) ^ ~HS_POL;
        w_raw.vsync = ((w_y_ext >= VS_START) && (w_y_ext < VS_END)) ^ ~VS_POL;
        w_raw.draw  = (w_x_ext < H_ACT_E) && (w_y_ext < V_ACT_E);
    end

    sig_delay #(
        .WIDTH   ($bits(sync_bits_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .i_en (en),
        .i_d  (w_raw),
        .o_q  (w_dly_out)
    );

    assign w_line_start  = en & ~rst & (r_x == 10'd0);

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_hsync       = w_dly_out.hsync;
    assign o_vsync       = w_dly_out.vsync;
    assign o_draw_area   = w_dly_out.draw;
    assign o_line_start  = w_line_start;
    assign o_frame_start = w_line_start & (r_y == 10'd0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: three generator instances against an arithmetic raster model driven by enabled-cycle count.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    // Instance A: default 640x480 timing
    logic [9:0] a_x, a_y;
    logic       a_hs, a_vs, a_draw, a_ls, a_fs;
    logic [7:0] a_fc;
    // Instance B: small raster, PIPE_DLY=3, active-low syncs
    logic [9:0] b_x, b_y;
    logic       b_hs, b_vs, b_draw, b_ls, b_fs;
    logic [7:0] b_fc;
    // Instance C: small raster, PIPE_DLY=1, active-high syncs (frame counter wrap)
    logic [9:0] c_x, c_y;
    logic       c_hs, c_vs, c_draw, c_ls, c_fs;
    logic [7:0] c_fc;

    video_timing_gen u_a (
        .clk(clk), .rst(rst), .en(en),
        .o_x(a_x), .o_y(a_y), .o_hsync(a_hs), .o_vsync(a_vs), .o_draw_area(a_draw),
        .o_line_start(a_ls), .o_frame_start(a_fs), .o_frame_cnt(a_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)
    ) u_b (
        .clk(clk), .rst(rst), .en(en),
        .o_x(b_x), .o_y(b_y), .o_hsync(b_hs), .o_vsync(b_vs), .o_draw_area(b_draw),
        .o_line_start(b_ls), .o_frame_start(b_fs), .o_frame_cnt(b_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(1)
    ) u_c (
        .clk(clk), .rst(rst), .en(en),
        .o_x(c_x), .o_y(c_y), .o_hsync(c_hs), .o_vsync(c_vs), .o_draw_area(c_draw),
        .o_line_start(c_ls), .o_frame_start(c_fs), .o_frame_cnt(c_fc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_en  = 0;   // enabled cycles since the last reset release
    int wrap_seen = 0;
    logic [7:0] c_fc_prev = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, n_en=%0d)", tag, got, exp, $time, n_en);
        end
    endtask

    // Reference: position is n mod line/frame length; strobes reflect the position dly enabled cycles ago.
    task automatic check_dut(input string nm,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input bit hpol, input bit vpol, input int dly,
                             input logic [9:0] x, input logic [9:0] y,
                             input logic hsync, input logic vsync, input logic draw,
                             input logic ls, input logic fs, input logic [7:0] fc);
        int ht, vt, ex, ey, ef, m, px, py;
        bit hs_act, vs_act, e_draw, e_ls, e_fs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ex = n_en % ht;
        ey = (n_en / ht) % vt;
        ef = (n_en / (ht * vt)) % 256;
        hs_act = 1'b0;
        vs_act = 1'b0;
        e_draw = 1'b0;
        if (n_en >= dly) begin
            m  = n_en - dly;
            px = m % ht;
            py = (m / ht) % vt;
            hs_act = (px >= ha + hf) && (px < ha + hf + hs);
            vs_act = (py >= va + vf) && (py < va + vf + vs);
            e_draw = (px < ha) && (py < va);
        end
        e_ls = en && !rst && (ex == 0);
        e_fs = e_ls && (ey == 0);
        check_eq({nm, ".x"},           32'(x),     32'(ex));
        check_eq({nm, ".y"},           32'(y),     32'(ey));
        check_eq({nm, ".frame_cnt"},   32'(fc),    32'(ef));
        check_eq({nm, ".hsync"},       32'(hsync), 32'(hs_act ? hpol : !hpol));
        check_eq({nm, ".vsync"},       32'(vsync), 32'(vs_act ? vpol : !vpol));
        check_eq({nm, ".draw_area"},   32'(draw),  32'(e_draw));
        check_eq({nm, ".line_start"},  32'(ls),    32'(e_ls));
        check_eq({nm, ".frame_start"}, 32'(fs),    32'(e_fs));
    endtask

    task automatic check_all();
        check_dut("A", 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 1,
                  a_x, a_y, a_hs, a_vs, a_draw, a_ls, a_fs, a_fc);
        check_dut("B", 8, 2, 3, 2, 6, 1, 2, 2, 1'b0, 1'b0, 3,
                  b_x, b_y, b_hs, b_vs, b_draw, b_ls, b_fs, b_fc);
        check_dut("C", 8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b1, 1,
                  c_x, c_y, c_hs, c_vs, c_draw, c_ls, c_fs, c_fc);
        if (c_fc_prev == 8'd255 && c_fc == 8'd0 && c_fs) wrap_seen++;
        c_fc_prev = c_fc;
    endtask

    // mode 0: en held high; mode 1: en random each cycle
    task automatic run_cycles(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            en = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            if (en && !rst) n_en++;
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic pulse_reset(input int cycles);
        en   = 1'b1;
        rst  = 1'b1;
        n_en = 0;
        #1 check_all();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            #1 check_all();
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        #1 check_all();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        en = 1'b1;
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        #1 check_all();

        run_cycles(400, 0);
        run_cycles(2000, 1);
        pulse_reset(3);
        run_cycles(42500, 0);
        run_cycles(600, 1);

        check_eq("C.frame_cnt_wrap_seen", 32'(wrap_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
